// File: rtl/neuron_layer_seq.sv
// Sequencer that time-multiplexes one MAC/bias/ReLU neuron datapath across
// every neuron of a fully-connected layer.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start           begin a layer (sampled only when idle)
//   busy            high whenever the sequencer is not idle
//   done            one-cycle pulse after the last neuron result is accepted
//   rd_en           weight/input ROM read enable
//   w_addr, x_addr  weight address (j*K + i) and input address (i)
//   mac_en          datapath accumulates the ROM product this cycle
//   acc_load        with mac_en: load the product instead of adding it
//   bias_idx        current neuron j, selects the bias
//   out_valid       ReLU result of neuron bias_idx is valid
//   out_ready       consumer accepts the result
module neuron_layer_seq #(
  parameter int unsigned NUM_INPUTS  = 16,
  parameter int unsigned NUM_NEURONS = 4,
  parameter int unsigned W_ADDR_W    = (NUM_INPUTS * NUM_NEURONS > 1) ?
                                       $clog2(NUM_INPUTS * NUM_NEURONS) : 1,
  parameter int unsigned X_ADDR_W    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  parameter int unsigned IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                rd_en,
  output logic [W_ADDR_W-1:0] w_addr,
  output logic [X_ADDR_W-1:0] x_addr,
  output logic                mac_en,
  output logic                acc_load,
  output logic [IDX_W-1:0]    bias_idx,
  output logic                out_valid,
  input  logic                out_ready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [X_ADDR_W-1:0] LAST_I = X_ADDR_W'(NUM_INPUTS - 1);
  localparam logic [IDX_W-1:0]    LAST_J = IDX_W'(NUM_NEURONS - 1);

  state_t state;

  // x_addr doubles as the input counter i and bias_idx as the neuron counter j.
  // w_addr walks linearly through the weight ROM, so it equals j*K + i
  // without a multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      w_addr    <= '0;
      x_addr    <= '0;
      mac_en    <= 1'b0;
      acc_load  <= 1'b0;
      bias_idx  <= '0;
      out_valid <= 1'b0;
    end else begin
      // MAC strobes trail the read by the ROM's one-cycle latency.
      mac_en   <= rd_en;
      acc_load <= rd_en && (x_addr == '0);
      done     <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            busy     <= 1'b1;
            rd_en    <= 1'b1;
            w_addr   <= '0;
            x_addr   <= '0;
            bias_idx <= '0;
          end
        end

        FETCH: begin
          if (x_addr == LAST_I) begin
            state <= DRAIN;
            rd_en <= 1'b0;
          end else begin
            x_addr <= x_addr + X_ADDR_W'(1);
            w_addr <= w_addr + W_ADDR_W'(1);
          end
        end

        // Last product is accumulated this cycle; result is ready next cycle.
        DRAIN: begin
          state     <= WRITE;
          out_valid <= 1'b1;
        end

        WRITE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (bias_idx == LAST_J) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= FETCH;
              rd_en    <= 1'b1;
              bias_idx <= bias_idx + IDX_W'(1);
              x_addr   <= '0;
              w_addr   <= w_addr + W_ADDR_W'(1);
            end
          end
        end

        DONE: begin
          state    <= IDLE;
          busy     <= 1'b0;
          w_addr   <= '0;
          x_addr   <= '0;
          bias_idx <= '0;
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          rd_en     <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_layer_seq.sv
// Self-checking bench for neuron_layer_seq: default 16x4 instance driving a
// behavioural ROM/MAC/bias/ReLU model, plus a 1x1 instance for the K=1 edge.
module tb_neuron_layer_seq;
  localparam int K = 16;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, out_ready;
  logic       busy, done, rd_en, mac_en, acc_load, out_valid;
  logic [5:0] w_addr;
  logic [3:0] x_addr;
  logic [1:0] bias_idx;

  logic start1;
  logic busy1, done1, rd_en1, mac_en1, acc_load1, out_valid1;
  logic w_addr1, x_addr1, bias_idx1;

  neuron_layer_seq #(.NUM_INPUTS(K), .NUM_NEURONS(N)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .w_addr(w_addr), .x_addr(x_addr), .mac_en(mac_en),
    .acc_load(acc_load), .bias_idx(bias_idx), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  neuron_layer_seq #(.NUM_INPUTS(1), .NUM_NEURONS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .rd_en(rd_en1), .w_addr(w_addr1), .x_addr(x_addr1), .mac_en(mac_en1),
    .acc_load(acc_load1), .bias_idx(bias_idx1), .out_valid(out_valid1),
    .out_ready(1'b1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;

  int w_mem [K*N];
  int x_mem [K];
  int bias  [N];

  // Behavioural datapath: ROM with one-cycle read latency feeding a MAC.
  int wq, xq, acc;
  always @(posedge clk) begin
    if (rd_en) begin
      wq <= w_mem[w_addr];
      xq <= x_mem[x_addr];
    end
    if (mac_en) acc <= acc_load ? wq * xq : acc + wq * xq;
  end

  // Monitor: counts strobes and captures accepted results, cycles relative to t0.
  int n_rd, n_mac, n_acc, n_done, addr_err, bad, exp_addr;
  int done_cyc, done_cyc2, rd_after_done;
  int obs_val[$], obs_idx[$], obs_cyc[$];
  int exp_val[$], exp_idx[$];

  always @(posedge clk) begin
    int rel, v;
    rel = cyc - t0;
    if (rd_en) begin
      n_rd++;
      if (w_addr !== 6'(exp_addr % (K*N)) || x_addr !== 4'(exp_addr % K)) addr_err++;
      if (out_valid) bad++;
      exp_addr++;
      if (n_done > 0 && rd_after_done < 0) rd_after_done = rel;
    end
    if (mac_en) begin
      n_mac++;
      if (out_valid || done || !busy) bad++;
    end
    if (acc_load) n_acc++;
    if (done) begin
      if (n_done == 0) done_cyc = rel;
      else if (n_done == 1) done_cyc2 = rel;
      n_done++;
    end
    if (out_valid && out_ready) begin
      v = acc + bias[bias_idx];
      obs_val.push_back(v < 0 ? 0 : v);
      obs_idx.push_back(int'(bias_idx));
      obs_cyc.push_back(rel);
    end
    cyc++;
  end

  function automatic int model(input int j);
    int s;
    s = 0;
    for (int i = 0; i < K; i++) s += w_mem[j*K + i] * x_mem[i];
    s += bias[j];
    return (s < 0) ? 0 : s;
  endfunction

  task automatic mon_clear();
    n_rd = 0; n_mac = 0; n_acc = 0; n_done = 0; addr_err = 0; bad = 0;
    exp_addr = 0; done_cyc = -1; done_cyc2 = -1; rd_after_done = -1;
    obs_val.delete(); obs_idx.delete(); obs_cyc.delete();
    exp_val.delete(); exp_idx.delete();
  endtask

  task automatic load_mem(input int wmode);
    for (int k = 0; k < K*N; k++) w_mem[k] = (wmode == 0) ? 1 : (k % 5) - 1;
    for (int i = 0; i < K; i++) x_mem[i] = i + 1;
    for (int j = 0; j < N; j++) bias[j] = 0;
  endtask

  task automatic push_expected();
    for (int j = 0; j < N; j++) begin
      exp_val.push_back(model(j));
      exp_idx.push_back(j);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string name);
    int n;
    n = 0;
    while (n_done == 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n_done == 0) begin
      checks++; errors++;
      $display("FAIL %s: done not seen within %0d cycles", name, limit);
    end
  endtask

  // Pops the scoreboard and compares every accepted result against the model.
  task automatic compare_results(input string name);
    int e, ei, o, oi;
    checks++;
    if (obs_val.size() != exp_val.size()) begin
      errors++;
      $display("FAIL %s result count: got %0d want %0d", name, obs_val.size(), exp_val.size());
    end
    while (exp_val.size() > 0 && obs_val.size() > 0) begin
      e = exp_val.pop_front(); ei = exp_idx.pop_front();
      o = obs_val.pop_front(); oi = obs_idx.pop_front();
      checks++;
      if (o !== e || oi !== ei) begin
        errors++;
        $display("FAIL %s result: got idx %0d val %0d want idx %0d val %0d", name, oi, o, ei, e);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start1 = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, rd_en, mac_en, acc_load, out_valid, w_addr, x_addr, bias_idx} !== 18'd0) begin
      errors++;
      $display("FAIL reset outputs: got %b want all zero",
               {busy, done, rd_en, mac_en, acc_load, out_valid, w_addr, x_addr, bias_idx});
    end
    checks++;
    if ({busy1, done1, rd_en1, mac_en1, acc_load1, out_valid1} !== 6'd0) begin
      errors++;
      $display("FAIL reset outputs k1: got %b want 000000",
               {busy1, done1, rd_en1, mac_en1, acc_load1, out_valid1});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timing();
    load_mem(0);
    mon_clear();
    push_expected();
    pulse_start();
    wait_done(200, "timing");
    checks++;
    if (done_cyc !== 73) begin errors++; $display("FAIL timing done cycle: got %0d want 73", done_cyc); end
    checks++;
    if (n_rd !== 64 || n_mac !== 64 || n_acc !== 4) begin
      errors++;
      $display("FAIL timing strobes: got rd %0d mac %0d load %0d want 64 64 4", n_rd, n_mac, n_acc);
    end
    checks++;
    if (addr_err !== 0 || bad !== 0) begin
      errors++;
      $display("FAIL timing addr/strobe: got addr_err %0d bad %0d want 0 0", addr_err, bad);
    end
    for (int j = 0; j < N && j < obs_cyc.size(); j++) begin
      checks++;
      if (obs_cyc[j] !== (j + 1) * (K + 2)) begin
        errors++;
        $display("FAIL timing out_valid cycle %0d: got %0d want %0d", j, obs_cyc[j], (j + 1) * (K + 2));
      end
    end
    compare_results("timing");
    repeat (2) @(negedge clk);
    checks++;
    if (n_done !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timing done pulse: got count %0d busy %b want 1 0", n_done, busy);
    end
  endtask

  task automatic test_relu();
    load_mem(0);
    bias[2] = -200;
    mon_clear();
    push_expected();
    pulse_start();
    wait_done(200, "relu");
    compare_results("relu");
    bias[2] = 0;
  endtask

  task automatic test_stall();
    int n;
    load_mem(1);
    bias[1] = 7; bias[3] = -3;
    mon_clear();
    push_expected();
    pulse_start();
    n = 0;
    while (!(out_valid && bias_idx == 2'd1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cyc - t0 !== 36) begin errors++; $display("FAIL stall first valid: got cycle %0d want 36", cyc - t0); end
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || bias_idx !== 2'd1 || rd_en !== 1'b0 || mac_en !== 1'b0) begin
        errors++;
        $display("FAIL stall hold %0d: got valid %b idx %0d rd %b mac %b want 1 1 0 0",
                 s, out_valid, bias_idx, rd_en, mac_en);
      end
    end
    out_ready = 1'b1;
    wait_done(200, "stall");
    checks++;
    if (done_cyc !== 78) begin errors++; $display("FAIL stall done cycle: got %0d want 78", done_cyc); end
    checks++;
    if (obs_cyc.size() != 4 || obs_cyc[1] !== 41 || obs_cyc[3] !== 77) begin
      errors++;
      $display("FAIL stall handshake cycles: got %p want 18 41 59 77", obs_cyc);
    end
    checks++;
    if (bad !== 0 || addr_err !== 0) begin
      errors++;
      $display("FAIL stall strobes: got bad %0d addr_err %0d want 0 0", bad, addr_err);
    end
    compare_results("stall");
    bias[1] = 0; bias[3] = 0;
  endtask

  task automatic test_reset_mid();
    int n;
    load_mem(0);
    mon_clear();
    pulse_start();
    n = 0;
    while (!(rd_en && bias_idx == 2'd2 && x_addr == 4'd7) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin errors++; $display("FAIL reset_mid: neuron 2 i=7 not reached, got %0d cycles", n); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, rd_en, mac_en, acc_load, out_valid, w_addr, x_addr, bias_idx} !== 18'd0) begin
      errors++;
      $display("FAIL reset_mid outputs: got %b want all zero",
               {busy, done, rd_en, mac_en, acc_load, out_valid, w_addr, x_addr, bias_idx});
    end
    repeat (5) @(negedge clk);
    checks++;
    if (n_done !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid stale done: got done count %0d busy %b want 0 0", n_done, busy);
    end
    mon_clear();
    push_expected();
    pulse_start();
    wait_done(200, "reset_mid restart");
    checks++;
    if (done_cyc !== 73 || addr_err !== 0) begin
      errors++;
      $display("FAIL reset_mid restart: got done %0d addr_err %0d want 73 0", done_cyc, addr_err);
    end
    compare_results("reset_mid");
  endtask

  task automatic test_back_to_back();
    int n;
    load_mem(1);
    mon_clear();
    push_expected();
    push_expected();
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    n = 0;
    while (n_done < 2 && n < 400) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    checks++;
    if (done_cyc !== 73 || done_cyc2 !== 147) begin
      errors++;
      $display("FAIL back_to_back done cycles: got %0d %0d want 73 147", done_cyc, done_cyc2);
    end
    checks++;
    if (rd_after_done !== 75 || n_rd !== 128) begin
      errors++;
      $display("FAIL back_to_back restart: got first rd %0d reads %0d want 75 128", rd_after_done, n_rd);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || n_done !== 2) begin
      errors++;
      $display("FAIL back_to_back idle: got busy %b done count %0d want 0 2", busy, n_done);
    end
    compare_results("back_to_back");
  endtask

  task automatic test_k1();
    logic [5:0] want [1:5];
    logic [5:0] got;
    // {rd_en, mac_en, acc_load, out_valid, done, busy} per cycle after start
    want[1] = 6'b100001;
    want[2] = 6'b011001;
    want[3] = 6'b000101;
    want[4] = 6'b000011;
    want[5] = 6'b000000;
    @(negedge clk);
    start1 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start1 = 1'b0;
      got = {rd_en1, mac_en1, acc_load1, out_valid1, done1, busy1};
      checks++;
      if (got !== want[c]) begin
        errors++;
        $display("FAIL k1 cycle %0d: got %b want %b", c, got, want[c]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_relu();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_k1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_layer_seq.md
Name: neuron_layer_seq

Overview:
- Controller that time-multiplexes one MAC/bias/ReLU neuron datapath across all neurons of a fully-connected layer.
- Generates weight-ROM and input-ROM read addresses and read enables.
- Generates MAC enable and accumulator-load strobes, aligned to the 1-cycle ROM read latency.
- Presents each finished neuron result on a valid/ready output handshake; sits between the layer-level top and the shared neuron datapath.

Parameters:
- NUM_INPUTS, 16, inputs per neuron (K); must be >= 1.
- NUM_NEURONS, 4, neurons in the layer (N); must be >= 1.
- W_ADDR_W, $clog2(NUM_INPUTS*NUM_NEURONS), weight ROM address width.
- X_ADDR_W, $clog2(NUM_INPUTS) (min 1), input ROM address width.
- IDX_W, $clog2(NUM_NEURONS) (min 1), neuron index width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin layer; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last neuron handshake.
- rd_en  out  1  ROM read enable.
- w_addr  out  W_ADDR_W  weight address = j*K + i.
- x_addr  out  X_ADDR_W  input address = i.
- mac_en  out  1  datapath accumulates product this cycle.
- acc_load  out  1  with mac_en: accumulator <= product (first term) instead of += product.
- bias_idx  out  IDX_W  current neuron j; selects bias.
- out_valid  out  1  ReLU result of neuron bias_idx is valid.
- out_ready  in  1  consumer accepts result.

Behaviour:
- Reset state: IDLE; every output 0; i = 0, j = 0.
- Reset applied mid-operation aborts the layer; the next cycle is IDLE with all outputs 0 and no done pulse.
- States: IDLE, FETCH, DRAIN, WRITE, DONE.
- IDLE: start=1 -> FETCH with i=0, j=0. start=0 -> stay.
- FETCH:
  - rd_en=1; w_addr=j*K+i; x_addr=i; bias_idx=j.
  - If i==K-1 -> DRAIN; else i++ and stay in FETCH.
- mac_en is rd_en registered one cycle, so the datapath sees ROM data together with mac_en.
- acc_load is (i==0 && rd_en) registered one cycle; it is high only on the first mac_en of each neuron.
- DRAIN (1 cycle): rd_en=0; the last product is accumulated (mac_en=1 from the delay) -> WRITE.
- WRITE:
  - out_valid=1; bias_idx=j held; no ROM reads.
  - out_ready=0: stay, outputs stable indefinitely.
  - out_ready=1 and j==N-1 -> DONE.
  - out_ready=1 and j<N-1 -> j++, i=0 -> FETCH.
- DONE: done=1 for exactly one cycle, busy=1 -> IDLE. start during DONE is ignored.
- start while busy is ignored; no queuing.
- K=1: each FETCH lasts a single cycle, and that one mac_en also carries acc_load.
- Timing with out_ready held 1:
  - Each neuron takes K+2 cycles.
  - start sampled at cycle 0 -> first FETCH at cycle 1 -> done high at cycle N*(K+2)+1.
  - A WRITE stall of s cycles delays done by s.
- Counters never exceed their range; w_addr never exceeds N*K-1.
- mac_en is never high in WRITE, IDLE or DONE, so the accumulator holds its value while a result is pending.

Test Plan:
- Default params, out_ready=1, pulse start at cycle 0 -> done at cycle 73.
  - w_addr sequence 0..63 with gaps of two cycles between neurons.
  - Exactly 64 mac_en pulses, 4 acc_load pulses, out_valid at cycles 18/36/54/72 with bias_idx 0..3.
- Datapath model with weights = 1, inputs = i+1, bias 0 -> each result = 136.
  - Negative bias -200 on neuron 2 -> ReLU output 0 for neuron 2 only.
- out_ready low for 5 cycles during neuron 1 WRITE.
  - out_valid and bias_idx are held; no rd_en or mac_en in that window.
  - done delayed to cycle 78.
- rst asserted during neuron 2 FETCH at i=7 -> next cycle all outputs 0.
  - A fresh start then restarts at w_addr 0; no stale done.
- start held high continuously -> layers run back to back.
  - IDLE is one cycle between done and the next first rd_en; start pulses while busy have no effect.
- NUM_INPUTS=1, NUM_NEURONS=1 -> rd_en at cycle 1; mac_en and acc_load at cycle 2; out_valid at cycle 3; done at cycle 4.
